ulpi_cfg_seq: RTL and testbench
===============================

ULPI_CFG_SEQ -- requirements
Module: ulpi_cfg_seq

Interface
REQ-001 The block SHALL have parameter STARTUP_CYCLES, default 1024, meaning PHY power-up wait after reset in ULPI_CLK cycles.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning maximum cycles any request waits for ACK.
REQ-003 ULPI_CLK  in  1  clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 REG_ADDR  out  6  register address toward the ULPI register port.
REQ-006 REG_DATA_WRITE  out  8  write data toward the ULPI register port.
REQ-007 REG_WRITE_REQ / REG_READ_REQ  out  1 each  register write / read request.
REQ-008 REG_WRITE_ACK / REG_READ_ACK  in  1 each  request acknowledge from the ULPI port.
REQ-009 REG_DATA_READ  in  8  read data, valid while REG_READ_ACK=1.
REQ-010 CMD_VALID, CMD_WRITE, CMD_ADDR[5:0], CMD_DATA[7:0]  in  host register command.
REQ-011 CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY.
REQ-012 RSP_VALID  out  1  one-cycle pulse on host command completion; RSP_DATA  out  8  read data (0x00 for writes).
REQ-013 DONE  out  1  init sequence complete and verified; ERROR  out  1  sticky failure flag.

Function
REQ-014 States SHALL be WAIT_PU, INIT_REQ, INIT_REL, VFY_REQ, VFY_REL, IDLE, HOST_REQ, HOST_REL, FAIL.
REQ-015 WAIT_PU SHALL count STARTUP_CYCLES cycles, then go to INIT_REQ with table index 0.
REQ-016 Init table SHALL be fixed, in order: (0x0A <- 0x00), (0x07 <- 0x00), (0x04 <- 0x48).
REQ-017 INIT_REQ SHALL drive table entry on REG_ADDR/REG_DATA_WRITE with REG_WRITE_REQ=1 until REG_WRITE_ACK=1, then go to INIT_REL.
REQ-018 Every *_REL state SHALL hold REQ=0 and wait until the corresponding ACK=0 before advancing; no new request while ACK=1.
REQ-019 REG_ADDR/REG_DATA_WRITE SHALL be stable from REQ rise until ACK observed; all outputs registered.
REQ-020 After index 2's INIT_REL, the block SHALL go to VFY_REQ: read 0x04 (REG_READ_REQ=1 until REG_READ_ACK=1), capture REG_DATA_READ on the ACK cycle.
REQ-021 Captured value 0x48 SHALL lead via VFY_REL to IDLE with DONE=1; any other value SHALL lead to FAIL.
REQ-022 A 8-bit timeout counter SHALL clear on REQ rise and increment each cycle REQ=1 without ACK; reaching ACK_TIMEOUT SHALL go to FAIL.
REQ-023 FAIL SHALL set ERROR=1, drop all REQs, set CMD_READY=0, and stay until RST.
REQ-024 CMD_READY SHALL be 1 only in IDLE; 0 in all other states including init.
REQ-025 On accept in IDLE, the block SHALL latch CMD fields and go to HOST_REQ issuing a write (CMD_WRITE=1) or read (CMD_WRITE=0), same handshake and timeout as init.
REQ-026 RSP_VALID SHALL pulse exactly one cycle on exit of HOST_REL to IDLE, with RSP_DATA = captured read data or 0x00; RSP_DATA holds until next response.
REQ-027 DONE SHALL stay 1 during host commands; a host timeout SHALL clear DONE and go to FAIL.
REQ-028 Never both REG_WRITE_REQ and REG_READ_REQ at 1.

Reset
REQ-029 On RST=1: state WAIT_PU, startup/timeout counters 0, index 0, all REQs 0, REG_ADDR 0, REG_DATA_WRITE 0, CMD_READY 0, RSP_VALID 0, RSP_DATA 0x00, DONE 0, ERROR 0.
REQ-030 RST mid-request SHALL drop REQ in the cycle after RST sampled; sequence restarts from WAIT_PU.

Verification
REQ-031 Reset release, ACK responder 2-cycle latency, read returns 0x48 -> writes 0x0A/0x00, 0x07/0x00, 0x04/0x48 in order after 1024 cycles, then read 0x04, DONE=1, CMD_READY=1.
REQ-032 Read returns 0x40 during verify -> ERROR=1, DONE=0, CMD_READY=0, no further REQs.
REQ-033 Responder never ACKs first write -> REG_WRITE_REQ high 255 cycles, then ERROR=1 and REQ=0.
REQ-034 CMD_VALID=1 held during init -> not accepted until DONE; then host read of 0x00 returning 0x24 -> one RSP_VALID pulse, RSP_DATA=0x24.
REQ-035 ACK held high 5 cycles after REQ drop -> next request not issued until ACK=0.
REQ-036 RST asserted while REG_WRITE_REQ=1 on entry 1 -> REQ=0 next cycle, DONE=0, full sequence repeats from entry 0.

Source files
------------

// File: rtl/ulpi_cfg_seq.sv
// ULPI PHY configuration sequencer: power-up wait, fixed register init, read-back verify,
// then a host register command port. Every output is a flop decoded from the next state.
module ulpi_cfg_seq #(
   parameter int unsigned STARTUP_CYCLES = 1024,
   parameter int unsigned ACK_TIMEOUT    = 255
) (
   input  logic       ULPI_CLK,
   input  logic       RST,
   output logic [5:0] REG_ADDR,
   output logic [7:0] REG_DATA_WRITE,
   output logic       REG_WRITE_REQ,
   output logic       REG_READ_REQ,
   input  logic       REG_WRITE_ACK,
   input  logic       REG_READ_ACK,
   input  logic [7:0] REG_DATA_READ,
   input  logic       CMD_VALID,
   input  logic       CMD_WRITE,
   input  logic [5:0] CMD_ADDR,
   input  logic [7:0] CMD_DATA,
   output logic       CMD_READY,
   output logic       RSP_VALID,
   output logic [7:0] RSP_DATA,
   output logic       DONE,
   output logic       ERROR
);

   localparam int unsigned SuW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
   localparam logic [SuW-1:0] SuLast   = SuW'(STARTUP_CYCLES - 1);
   localparam logic [7:0]     TmoLimit = 8'(ACK_TIMEOUT);
   localparam logic [5:0]     VfyAddr  = 6'h04;
   localparam logic [7:0]     VfyData  = 8'h48;

   typedef enum logic [3:0] {
      StWaitPu, StInitReq, StInitRel, StVfyReq, StVfyRel, StIdle, StHostReq, StHostRel, StFail
   } state_e;

   function automatic logic [13:0] init_entry(input logic [1:0] idx);
      logic [13:0] entry;
      case (idx)
         2'd0:    entry = {6'h0A, 8'h00};
         2'd1:    entry = {6'h07, 8'h00};
         default: entry = {VfyAddr, VfyData};
      endcase
      return entry;
   endfunction

   state_e         state_q, state_d;
   logic [SuW-1:0] su_q, su_d;
   logic [7:0]     tmo_q, tmo_d, tmo_inc;
   logic           tmo_hit;
   logic [1:0]     idx_q, idx_d;
   logic [7:0]     rd_q, rd_d;
   logic           cmd_write_q, cmd_write_d;
   logic [5:0]     cmd_addr_q, cmd_addr_d;
   logic [7:0]     cmd_data_q, cmd_data_d;
   logic           host_ack;
   logic [5:0]     addr_q, addr_d;
   logic [7:0]     wdata_q, wdata_d;
   logic           wreq_q, wreq_d, rreq_q, rreq_d;
   logic           ready_q, ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [7:0]     rsp_data_q, rsp_data_d;
   logic           done_q, done_d, error_q, error_d;

   always_comb begin
      state_d     = state_q;
      su_d        = su_q;
      tmo_d       = '0;
      idx_d       = idx_q;
      rd_d        = rd_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      tmo_inc     = tmo_q + 8'd1;
      tmo_hit     = (tmo_inc == TmoLimit);
      host_ack    = cmd_write_q ? REG_WRITE_ACK : REG_READ_ACK;

      // The timeout counter only runs while a request is outstanding; leaving a
      // request state returns it to zero, so every request rise starts from zero.
      unique case (state_q)
         StWaitPu: begin
            if (su_q == SuLast) begin
               state_d = StInitReq;
               idx_d   = 2'd0;
            end else begin
               su_d = su_q + SuW'(1);
            end
         end
         StInitReq: begin
            if (REG_WRITE_ACK) begin
               state_d = StInitRel;
            end else if (tmo_hit) begin
               state_d = StFail;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         StInitRel: begin
            if (!REG_WRITE_ACK) begin
               if (idx_q == 2'd2) begin
                  state_d = StVfyReq;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = StInitReq;
               end
            end
         end
         StVfyReq: begin
            if (REG_READ_ACK) begin
               rd_d    = REG_DATA_READ;
               state_d = (REG_DATA_READ == VfyData) ? StVfyRel : StFail;
            end else if (tmo_hit) begin
               state_d = StFail;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         StVfyRel: begin
            if (!REG_READ_ACK) state_d = StIdle;
         end
         StIdle: begin
            if (CMD_VALID) begin
               cmd_write_d = CMD_WRITE;
               cmd_addr_d  = CMD_ADDR;
               cmd_data_d  = CMD_DATA;
               state_d     = StHostReq;
            end
         end
         StHostReq: begin
            if (host_ack) begin
               rd_d    = cmd_write_q ? 8'h00 : REG_DATA_READ;
               state_d = StHostRel;
            end else if (tmo_hit) begin
               state_d = StFail;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         StHostRel: begin
            if (!host_ack) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rd_q;
            end
         end
         StFail:  state_d = StFail;
         default: state_d = StFail;
      endcase

      wreq_d  = (state_d == StInitReq) || ((state_d == StHostReq) && cmd_write_d);
      rreq_d  = (state_d == StVfyReq) || ((state_d == StHostReq) && !cmd_write_d);
      ready_d = (state_d == StIdle);
      done_d  = (state_d == StIdle) || (state_d == StHostReq) || (state_d == StHostRel);
      error_d = (state_d == StFail);

      if (state_d == StInitReq) begin
         {addr_d, wdata_d} = init_entry(idx_d);
      end else if (state_d == StVfyReq) begin
         addr_d = VfyAddr;
      end else if (state_d == StHostReq) begin
         addr_d  = cmd_addr_d;
         wdata_d = cmd_data_d;
      end
   end

   always_ff @(posedge ULPI_CLK) begin
      if (RST) begin
         state_q     <= StWaitPu;
         su_q        <= '0;
         tmo_q       <= '0;
         idx_q       <= '0;
         rd_q        <= '0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wreq_q      <= 1'b0;
         rreq_q      <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         su_q        <= su_d;
         tmo_q       <= tmo_d;
         idx_q       <= idx_d;
         rd_q        <= rd_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wreq_q      <= wreq_d;
         rreq_q      <= rreq_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign REG_ADDR       = addr_q;
   assign REG_DATA_WRITE = wdata_q;
   assign REG_WRITE_REQ  = wreq_q;
   assign REG_READ_REQ   = rreq_q;
   assign CMD_READY      = ready_q;
   assign RSP_VALID      = rsp_valid_q;
   assign RSP_DATA       = rsp_data_q;
   assign DONE           = done_q;
   assign ERROR          = error_q;

endmodule

// File: tb/tb_ulpi_cfg_seq.sv
// Bench for ulpi_cfg_seq: table of init/verify scenarios plus hand-written host, timeout
// and reset sequences, against a behavioural ULPI register-port responder.
module tb_ulpi_cfg_seq;

   logic       ULPI_CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] REG_ADDR;
   logic [7:0] REG_DATA_WRITE;
   logic       REG_WRITE_REQ, REG_READ_REQ;
   logic       REG_WRITE_ACK = 1'b0, REG_READ_ACK = 1'b0;
   logic [7:0] REG_DATA_READ = 8'h00;
   logic       CMD_VALID = 1'b0, CMD_WRITE = 1'b0;
   logic [5:0] CMD_ADDR = 6'h00;
   logic [7:0] CMD_DATA = 8'h00;
   logic       CMD_READY, RSP_VALID;
   logic [7:0] RSP_DATA;
   logic       DONE, ERROR;

   ulpi_cfg_seq dut (
      .ULPI_CLK      (ULPI_CLK),
      .RST           (RST),
      .REG_ADDR      (REG_ADDR),
      .REG_DATA_WRITE(REG_DATA_WRITE),
      .REG_WRITE_REQ (REG_WRITE_REQ),
      .REG_READ_REQ  (REG_READ_REQ),
      .REG_WRITE_ACK (REG_WRITE_ACK),
      .REG_READ_ACK  (REG_READ_ACK),
      .REG_DATA_READ (REG_DATA_READ),
      .CMD_VALID     (CMD_VALID),
      .CMD_WRITE     (CMD_WRITE),
      .CMD_ADDR      (CMD_ADDR),
      .CMD_DATA      (CMD_DATA),
      .CMD_READY     (CMD_READY),
      .RSP_VALID     (RSP_VALID),
      .RSP_DATA      (RSP_DATA),
      .DONE          (DONE),
      .ERROR         (ERROR)
   );

   always #5 ULPI_CLK = ~ULPI_CLK;

   int checks = 0;
   int errors = 0;

   // Responder configuration, set by the test.
   logic [7:0] vfy_val   = 8'h48;
   logic [7:0] host_val  = 8'h00;
   int         hold      = 0;
   bit         never_ack = 1'b0;

   // Monitor state.
   logic [14:0] log_q[$];
   int          cyc = 0, nrise = 0, first_rise = -1, len = 0, last_len = 0, rsp_cnt = 0;
   int          cnt = 0, hcnt = 0;
   bit          prev_req = 1'b0;
   logic [5:0]  rise_a;
   logic [7:0]  rise_d;
   logic [14:0] exp_tx[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor and ACK responder, evaluated 2 time units after each rising edge.
   initial begin
      forever begin
         @(posedge ULPI_CLK);
         #2;
         if (RST) begin
            REG_WRITE_ACK = 1'b0;
            REG_READ_ACK  = 1'b0;
            REG_DATA_READ = 8'h00;
            cnt = 0; hcnt = 0; cyc = 0; nrise = 0; first_rise = -1; rsp_cnt = 0;
            prev_req = 1'b0;
            log_q.delete();
         end else begin
            bit req_now;
            cyc++;
            req_now = REG_WRITE_REQ | REG_READ_REQ;
            if (REG_WRITE_REQ && REG_READ_REQ) begin
               errors++;
               $display("FAIL both_req: write and read requests both 1 at cycle %0d", cyc);
            end
            if (req_now && !prev_req) begin
               nrise++;
               checks++;
               if (REG_WRITE_ACK || REG_READ_ACK) begin
                  errors++;
                  $display("FAIL req_while_ack: request rose with ack=1, required ack=0");
               end
               rise_a = REG_ADDR;
               rise_d = REG_DATA_WRITE;
               len = 0;
               if (first_rise < 0) first_rise = cyc;
            end
            if (req_now) begin
               len++;
               if (REG_ADDR !== rise_a || REG_DATA_WRITE !== rise_d) begin
                  errors++;
                  $display("FAIL addr_stable: got %0h/%0h, required %0h/%0h",
                           REG_ADDR, REG_DATA_WRITE, rise_a, rise_d);
               end
            end
            if (!req_now && prev_req) last_len = len;
            if (RSP_VALID) rsp_cnt++;
            prev_req = req_now;

            if (REG_WRITE_ACK || REG_READ_ACK) begin
               if (!req_now) begin
                  if (hcnt >= hold) begin
                     REG_WRITE_ACK = 1'b0;
                     REG_READ_ACK  = 1'b0;
                     hcnt = 0;
                     cnt  = 0;
                  end else begin
                     hcnt++;
                  end
               end
            end else if (req_now && !never_ack) begin
               cnt++;
               if (cnt >= 2) begin
                  if (REG_WRITE_REQ) begin
                     REG_WRITE_ACK = 1'b1;
                     log_q.push_back({1'b1, REG_ADDR, REG_DATA_WRITE});
                  end else begin
                     REG_READ_ACK  = 1'b1;
                     REG_DATA_READ = (REG_ADDR == 6'h04) ? vfy_val : host_val;
                     log_q.push_back({1'b0, REG_ADDR, 8'h00});
                  end
               end
            end
         end
      end
   end

   task automatic apply_reset();
      @(negedge ULPI_CLK);
      RST = 1'b1;
      CMD_VALID = 1'b0;
      repeat (3) @(negedge ULPI_CLK);
      chk("rst_wreq", REG_WRITE_REQ, 0);
      chk("rst_rreq", REG_READ_REQ, 0);
      chk("rst_addr", REG_ADDR, 0);
      chk("rst_wdata", REG_DATA_WRITE, 0);
      chk("rst_ready", CMD_READY, 0);
      chk("rst_rspv", RSP_VALID, 0);
      chk("rst_rspd", RSP_DATA, 0);
      chk("rst_done", DONE, 0);
      chk("rst_error", ERROR, 0);
      RST = 1'b0;
   endtask

   task automatic wait_end(input int budget, input string name);
      int n = 0;
      while (!(DONE || ERROR) && n < budget) begin
         @(negedge ULPI_CLK);
         n++;
      end
      if (!(DONE || ERROR)) begin
         checks++;
         errors++;
         $display("FAIL %s: no DONE/ERROR within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_rsp(input int n_rsp, input int budget, input string name);
      int n = 0;
      while (rsp_cnt < n_rsp && n < budget) begin
         @(negedge ULPI_CLK);
         n++;
      end
      if (rsp_cnt < n_rsp) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d responses, required %0d", name, rsp_cnt, n_rsp);
      end
   endtask

   task automatic send_cmd(input logic w, input logic [5:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge ULPI_CLK);
      while (!CMD_READY && n < 100) begin
         @(negedge ULPI_CLK);
         n++;
      end
      chk("cmd_ready_seen", CMD_READY, 1);
      CMD_VALID = 1'b1;
      CMD_WRITE = w;
      CMD_ADDR  = a;
      CMD_DATA  = d;
      @(negedge ULPI_CLK);
      CMD_VALID = 1'b0;
   endtask

   task automatic chk_log(input int k, input logic [14:0] exp, input string name);
      if (k < log_q.size()) chk(name, log_q[k], exp);
      else chk(name, log_q.size(), k + 1);
   endtask

   task automatic chk_init_log(input string tag);
      for (int k = 0; k < 4; k++) chk_log(k, exp_tx[k], $sformatf("%s_tx%0d", tag, k));
      chk($sformatf("%s_first_req_cycle", tag), first_rise, 1024);
   endtask

   typedef struct {
      logic [7:0] vfy;
      int         hold;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_tx[0] = {1'b1, 6'h0A, 8'h00};
      exp_tx[1] = {1'b1, 6'h07, 8'h00};
      exp_tx[2] = {1'b1, 6'h04, 8'h48};
      exp_tx[3] = {1'b0, 6'h04, 8'h00};
      vecs[0] = '{vfy: 8'h48, hold: 0, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{vfy: 8'h40, hold: 0, exp_done: 1'b0, exp_err: 1'b1};
      vecs[2] = '{vfy: 8'h48, hold: 5, exp_done: 1'b1, exp_err: 1'b0};
      vecs[3] = '{vfy: 8'h49, hold: 2, exp_done: 1'b0, exp_err: 1'b1};

      // Init/verify scenarios.
      for (int i = 0; i < 4; i++) begin
         vfy_val   = vecs[i].vfy;
         hold      = vecs[i].hold;
         never_ack = 1'b0;
         apply_reset();
         wait_end(3000, $sformatf("v%0d_end", i));
         repeat (40) @(negedge ULPI_CLK);
         chk($sformatf("v%0d_done", i), DONE, vecs[i].exp_done);
         chk($sformatf("v%0d_error", i), ERROR, vecs[i].exp_err);
         chk($sformatf("v%0d_ready", i), CMD_READY, vecs[i].exp_done);
         chk($sformatf("v%0d_reqs", i), {REG_WRITE_REQ, REG_READ_REQ}, 0);
         chk($sformatf("v%0d_nreq", i), nrise, 4);
         chk_init_log($sformatf("v%0d", i));
      end
      hold = 0;

      // First write never acknowledged.
      never_ack = 1'b1;
      vfy_val   = 8'h48;
      apply_reset();
      wait_end(2000, "tmo_end");
      @(negedge ULPI_CLK);
      chk("tmo_error", ERROR, 1);
      chk("tmo_done", DONE, 0);
      chk("tmo_wreq", REG_WRITE_REQ, 0);
      chk("tmo_len", last_len, 255);
      chk("tmo_nreq", nrise, 1);
      never_ack = 1'b0;

      // Command held valid through init; then host read and host write.
      host_val = 8'h24;
      apply_reset();
      CMD_VALID = 1'b1;
      CMD_WRITE = 1'b0;
      CMD_ADDR  = 6'h00;
      CMD_DATA  = 8'h5A;
      wait_end(3000, "cmd_end");
      chk("cmd_done", DONE, 1);
      chk("cmd_no_early", log_q.size(), 4);
      @(negedge ULPI_CLK);
      CMD_VALID = 1'b0;
      begin
         int n = 0;
         while (!REG_READ_REQ && n < 20) begin
            @(negedge ULPI_CLK);
            n++;
         end
      end
      chk("host_rreq", REG_READ_REQ, 1);
      chk("host_addr", REG_ADDR, 6'h00);
      chk("host_done_held", DONE, 1);
      chk("host_ready_busy", CMD_READY, 0);
      wait_rsp(1, 100, "host_rd_rsp");
      repeat (5) @(negedge ULPI_CLK);
      chk("host_rd_pulses", rsp_cnt, 1);
      chk("host_rd_data", RSP_DATA, 8'h24);
      chk_log(4, {1'b0, 6'h00, 8'h00}, "host_rd_tx");
      chk("host_ready_back", CMD_READY, 1);

      send_cmd(1'b1, 6'h15, 8'hA3);
      wait_rsp(2, 100, "host_wr_rsp");
      repeat (5) @(negedge ULPI_CLK);
      chk("host_wr_pulses", rsp_cnt, 2);
      chk("host_wr_data", RSP_DATA, 8'h00);
      chk_log(5, {1'b1, 6'h15, 8'hA3}, "host_wr_tx");

      // Host request that is never acknowledged.
      never_ack = 1'b1;
      send_cmd(1'b0, 6'h2A, 8'h00);
      begin
         int n = 0;
         while (!ERROR && n < 400) begin
            @(negedge ULPI_CLK);
            n++;
         end
      end
      @(negedge ULPI_CLK);
      chk("htmo_error", ERROR, 1);
      chk("htmo_done", DONE, 0);
      chk("htmo_ready", CMD_READY, 0);
      chk("htmo_reqs", {REG_WRITE_REQ, REG_READ_REQ}, 0);
      chk("htmo_len", last_len, 255);
      never_ack = 1'b0;

      // Reset while the second init write is outstanding.
      apply_reset();
      begin
         int n = 0;
         while (!(REG_WRITE_REQ && REG_ADDR == 6'h07) && n < 2000) begin
            @(negedge ULPI_CLK);
            n++;
         end
      end
      chk("mid_seen", {REG_WRITE_REQ, REG_ADDR}, {1'b1, 6'h07});
      RST = 1'b1;
      @(posedge ULPI_CLK);
      #1;
      chk("mid_req_drop", REG_WRITE_REQ, 0);
      chk("mid_done", DONE, 0);
      @(negedge ULPI_CLK);
      RST = 1'b0;
      wait_end(3000, "mid_end");
      repeat (5) @(negedge ULPI_CLK);
      chk("mid_redone", DONE, 1);
      chk_init_log("mid");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
